// File: rtl/gray_rd_if.sv
// Read-port bundle shared between the gray-image arbiter, its two requesters and the image memory.
// slave = arbiter side, master = requester/memory side.
interface gray_rd_if #(
    parameter int AW = 14,
    parameter int DW = 8
);
    logic          req0;
    logic [AW-1:0] addr0;
    logic          gnt0;
    logic          rvalid0;
    logic          req1;
    logic [AW-1:0] addr1;
    logic          gnt1;
    logic          rvalid1;
    logic [DW-1:0] rdata;
    logic [AW-1:0] gray_addr;
    logic          gray_req;
    logic          gray_ready;
    logic [DW-1:0] gray_data;
    logic [1:0]    owner;

    modport slave (
        input  req0, addr0, req1, addr1, gray_ready, gray_data,
        output gnt0, rvalid0, gnt1, rvalid1, rdata, gray_addr, gray_req, owner
    );

    modport master (
        output req0, addr0, req1, addr1, gray_ready, gray_data,
        input  gnt0, rvalid0, gnt1, rvalid1, rdata, gray_addr, gray_req, owner
    );
endinterface

// File: rtl/gray_rd_arbiter.sv
// Round-robin arbiter for the single gray-image read port: LBP window engine (port 0)
// and auxiliary reader (port 1), bursts of up to BURST beats per ownership.
//
//   state | meaning
//   IDLE  | no owner; arbitrate, no grants this cycle
//   OWN0  | port 0 owns the read port, beats granted while req0 & gray_ready
//   OWN1  | port 1 owns the read port, beats granted while req1 & gray_ready
module gray_rd_arbiter #(
    parameter int AW    = 14,
    parameter int DW    = 8,
    parameter int BURST = 9
) (
    input  logic       clk,
    input  logic       reset,
    gray_rd_if.slave   bus
);
    localparam int             BW        = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BW-1:0]  LAST_BEAT = BW'(BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;
    logic          last_q, last_d;
    logic [AW-1:0] gray_addr_q, gray_addr_d;
    logic          gray_req_q, gray_req_d;
    logic          rtag_q, rtag_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;

    logic          gnt0, gnt1;
    logic          own_req, other_req, own_gnt, leave;
    state_t        other_state;

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        last_d      = last_q;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        own_req     = 1'b0;
        other_req   = 1'b0;
        own_gnt     = 1'b0;
        leave       = 1'b0;
        other_state = IDLE;

        case (state_q)
            IDLE: begin
                if (bus.gray_ready && (bus.req0 || bus.req1)) begin
                    // last_q names the previous owner; the other port wins a tie
                    if (bus.req0 && bus.req1) state_d = last_q ? OWN0 : OWN1;
                    else                      state_d = bus.req0 ? OWN0 : OWN1;
                    beat_cnt_d = '0;
                end
            end
            OWN0, OWN1: begin
                own_req     = (state_q == OWN0) ? bus.req0 : bus.req1;
                other_req   = (state_q == OWN0) ? bus.req1 : bus.req0;
                other_state = (state_q == OWN0) ? OWN1 : OWN0;
                own_gnt     = own_req && bus.gray_ready;
                leave       = bus.gray_ready && (!own_req || (own_gnt && beat_cnt_q == LAST_BEAT));
                gnt0        = own_gnt && (state_q == OWN0);
                gnt1        = own_gnt && (state_q == OWN1);
                if (own_gnt) beat_cnt_d = beat_cnt_q + BW'(1);
                if (leave) begin
                    last_d     = (state_q == OWN1);
                    beat_cnt_d = '0;
                    if (other_req)    state_d = other_state;
                    else if (own_req) state_d = state_q;
                    else              state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        gray_req_d  = gnt0 || gnt1;
        gray_addr_d = gnt0 ? bus.addr0 : (gnt1 ? bus.addr1 : gray_addr_q);
        // Tag rides with gray_req so returns are steered in exact grant order
        rtag_d      = gnt1;
        rvalid0_d   = gray_req_q && !rtag_q;
        rvalid1_d   = gray_req_q && rtag_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            last_q      <= 1'b1;
            gray_addr_q <= '0;
            gray_req_q  <= 1'b0;
            rtag_q      <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            last_q      <= last_d;
            gray_addr_q <= gray_addr_d;
            gray_req_q  <= gray_req_d;
            rtag_q      <= rtag_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
        end
    end

    assign bus.gnt0      = gnt0;
    assign bus.gnt1      = gnt1;
    assign bus.rvalid0   = rvalid0_q;
    assign bus.rvalid1   = rvalid1_q;
    assign bus.rdata     = bus.gray_data;
    assign bus.gray_addr = gray_addr_q;
    assign bus.gray_req  = gray_req_q;
    assign bus.owner     = state_q;
endmodule

// File: tb/tb_gray_rd_arbiter.sv
// Bench for gray_rd_arbiter: directed cycle table, multi-cycle corner sequences and
// random traffic, all checked against a tenure/return-queue model of the arbiter.
module tb_gray_rd_arbiter;
    localparam int AW    = 14;
    localparam int DW    = 8;
    localparam int BURST = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;

    gray_rd_if #(.AW(AW), .DW(DW)) bus ();

    gray_rd_arbiter #(.AW(AW), .DW(DW), .BURST(BURST)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        logic [AW-1:0] t;
        t = a ^ (a >> 7);
        return t[7:0] * 8'd37 + 8'd11;
    endfunction

    always @(posedge clk) bus.gray_data <= mem_f(bus.gray_addr);

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    // Model: current owner (-1 none), port preferred on a tie, beats left in tenure,
    // registered memory strobe/address, and a queue of returns due at a given cycle.
    typedef struct {
        int            port;
        logic [AW-1:0] addr;
        int            due;
    } pend_t;

    int            m_own;
    int            m_pref;
    int            m_left;
    logic          m_greq;
    logic [AW-1:0] m_gaddr;
    pend_t         pend[$];

    task automatic model_reset();
        m_own   = -1;
        m_pref  = 0;
        m_left  = BURST;
        m_greq  = 1'b0;
        m_gaddr = '0;
        pend.delete();
    endtask

    task automatic cycle(input logic r, input logic rdy, input logic q0, input logic q1,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        logic [1:0]    rq;
        logic [1:0]    g;
        logic          e_rv0, e_rv1;
        logic [DW-1:0] e_rd;
        logic [1:0]    e_own;
        pend_t         pe;
        int            p;
        logic          got;
        @(negedge clk);
        rst = r;
        bus.gray_ready = rdy;
        bus.req0 = q0;
        bus.req1 = q1;
        bus.addr0 = a0;
        bus.addr1 = a1;
        #1;
        rq = {q1, q0};
        if (r) model_reset();
        g[0] = (m_own == 0) && q0 && rdy;
        g[1] = (m_own == 1) && q1 && rdy;
        e_rv0 = 1'b0;
        e_rv1 = 1'b0;
        e_rd  = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            pe = pend.pop_front();
            if (pe.port == 0) e_rv0 = 1'b1;
            else              e_rv1 = 1'b1;
            e_rd = mem_f(pe.addr);
        end
        e_own = (m_own < 0) ? 2'b00 : ((m_own == 0) ? 2'b01 : 2'b10);
        chk("gnt0", 32'(bus.gnt0), 32'(g[0]));
        chk("gnt1", 32'(bus.gnt1), 32'(g[1]));
        chk("owner", 32'(bus.owner), 32'(e_own));
        chk("gray_req", 32'(bus.gray_req), 32'(m_greq));
        chk("gray_addr", 32'(bus.gray_addr), 32'(m_gaddr));
        chk("rvalid0", 32'(bus.rvalid0), 32'(e_rv0));
        chk("rvalid1", 32'(bus.rvalid1), 32'(e_rv1));
        if (e_rv0 || e_rv1) chk("rdata", 32'(bus.rdata), 32'(e_rd));
        if (!r) begin
            if (g != 2'b00) begin
                p = g[0] ? 0 : 1;
                pend.push_back('{port: p, addr: (p == 0) ? a0 : a1, due: cyc + 2});
                m_greq  = 1'b1;
                m_gaddr = (p == 0) ? a0 : a1;
            end else begin
                m_greq = 1'b0;
            end
            if (m_own < 0) begin
                if (rdy && (q0 || q1)) begin
                    m_own  = (q0 && q1) ? m_pref : (q0 ? 0 : 1);
                    m_left = BURST;
                end
            end else if (rdy) begin
                p   = m_own;
                got = g[p];
                if (got) m_left--;
                if (!rq[p] || (got && m_left == 0)) begin
                    m_pref = 1 - p;
                    m_left = BURST;
                    m_own  = rq[1-p] ? 1 - p : (rq[p] ? p : -1);
                end
            end
        end
        cyc++;
    endtask

    typedef struct {
        logic          r, rdy, q0, q1;
        logic [AW-1:0] a0, a1;
        logic          g0, g1;
        logic [1:0]    own;
        logic          greq;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic rdy, input logic q0, input logic q1,
                       input logic g0, input logic g1, input logic [1:0] own, input logic greq);
        tbl.push_back('{r: r, rdy: rdy, q0: q0, q1: q1, a0: 14'h0081, a1: 14'h1234,
                        g0: g0, g1: g1, own: own, greq: greq});
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 0, '0, '0);
        cycle(1, 0, 0, 0, '0, '0);
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, '0, '0);
    endtask

    int            cnt0, cnt1, cntv;
    logic          rq0, rq1;
    logic [AW-1:0] ra0, ra1;

    initial begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.addr0 = '0;
        bus.addr1 = '0;
        bus.gray_ready = 1'b0;
        model_reset();

        // Ready gating, ownership switches and idle return, one row per cycle
        add(1, 1, 1, 0, 0, 0, 2'b00, 0);
        add(1, 1, 1, 0, 0, 0, 2'b00, 0);
        add(0, 0, 1, 0, 0, 0, 2'b00, 0);
        add(0, 0, 1, 0, 0, 0, 2'b00, 0);
        add(0, 1, 1, 0, 0, 0, 2'b00, 0);
        add(0, 1, 1, 0, 1, 0, 2'b01, 0);
        add(0, 1, 1, 0, 1, 0, 2'b01, 1);
        add(0, 0, 1, 0, 0, 0, 2'b01, 1);
        add(0, 0, 1, 0, 0, 0, 2'b01, 0);
        add(0, 1, 0, 1, 0, 0, 2'b01, 0);
        add(0, 1, 0, 1, 0, 1, 2'b10, 0);
        add(0, 1, 1, 0, 0, 0, 2'b10, 1);
        add(0, 1, 1, 0, 1, 0, 2'b01, 0);
        add(0, 1, 0, 0, 0, 0, 2'b01, 1);
        add(0, 1, 0, 0, 0, 0, 2'b00, 0);
        foreach (tbl[i]) begin
            cycle(tbl[i].r, tbl[i].rdy, tbl[i].q0, tbl[i].q1, tbl[i].a0, tbl[i].a1);
            chk($sformatf("tbl%0d_gnt0", i), 32'(bus.gnt0), 32'(tbl[i].g0));
            chk($sformatf("tbl%0d_gnt1", i), 32'(bus.gnt1), 32'(tbl[i].g1));
            chk($sformatf("tbl%0d_owner", i), 32'(bus.owner), 32'(tbl[i].own));
            chk($sformatf("tbl%0d_greq", i), 32'(bus.gray_req), 32'(tbl[i].greq));
        end
        drain();

        // Single requester holding req0 past a full burst: re-grant with no bubble
        do_reset();
        cycle(0, 1, 1, 0, 14'h0081, '0);
        cnt0 = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, 1, 0, 14'h0081, '0);
            if (bus.gnt0) cnt0++;
        end
        chk("t1_gnt0_count", 32'(cnt0), 32'd10);
        drain();

        // Both requesting from idle: port 0 first for 9, port 1 for 9, then port 0
        do_reset();
        cycle(0, 1, 1, 1, 14'h0100, 14'h0200);
        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < 9; i++) begin
            cycle(0, 1, 1, 1, 14'(14'h0100 + i), 14'h0200);
            if (bus.gnt0) cnt0++;
            if (bus.gnt1) cnt1++;
        end
        chk("t2_port0_beats", 32'(cnt0), 32'd9);
        chk("t2_port0_only", 32'(cnt1), 32'd0);
        cnt1 = 0;
        for (int i = 0; i < 9; i++) begin
            cycle(0, 1, 1, 1, 14'h0100, 14'(14'h0200 + i));
            if (bus.gnt1) cnt1++;
        end
        chk("t2_port1_beats", 32'(cnt1), 32'd9);
        cycle(0, 1, 1, 1, 14'h0300, 14'h0200);
        chk("t2_back_to_port0", 32'(bus.gnt0), 32'd1);
        drain();

        // gray_ready dropped after beat 4: two returns finish, burst still totals 9
        do_reset();
        cycle(0, 1, 1, 1, 14'h0400, 14'h0500);
        cnt0 = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 1, 1, 14'(14'h0400 + i), 14'h0500);
            if (bus.gnt0) cnt0++;
        end
        cntv = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1, 1, 14'h0404, 14'h0500);
            if (bus.rvalid0) cntv++;
            chk("t4_no_gnt_when_not_ready", 32'(bus.gnt0), 32'd0);
        end
        chk("t4_inflight_rvalid", 32'(cntv), 32'd2);
        for (int i = 0; i < 6; i++) begin
            cycle(0, 1, 1, 1, 14'(14'h0404 + i), 14'h0500);
            if (bus.gnt0) cnt0++;
        end
        chk("t4_total_beats", 32'(cnt0), 32'd9);
        chk("t4_switched_owner", 32'(bus.owner), 32'd2);
        drain();

        // req1 drops after 2 beats while req0 waits: switch, returns in grant order
        do_reset();
        cycle(0, 1, 0, 1, 14'h0600, 14'h0700);
        cycle(0, 1, 1, 1, 14'h0600, 14'h0700);
        cycle(0, 1, 1, 1, 14'h0600, 14'h0701);
        cycle(0, 1, 1, 0, 14'h0600, 14'h0702);
        chk("t5_no_gnt_on_drop", 32'(bus.gnt0 | bus.gnt1), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 1, 0, 14'(14'h0600 + i), 14'h0702);
            chk("t5_rvalid_exclusive", 32'(bus.rvalid0 & bus.rvalid1), 32'd0);
        end
        drain();

        // Reset asserted mid-cycle during port 1 beat 3
        do_reset();
        cycle(0, 1, 0, 1, '0, 14'h0800);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 1, '0, 14'(14'h0800 + i));
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_owner_async", 32'(bus.owner), 32'd0);
        chk("t6_greq_async", 32'(bus.gray_req), 32'd0);
        chk("t6_rvalid0_async", 32'(bus.rvalid0), 32'd0);
        chk("t6_rvalid1_async", 32'(bus.rvalid1), 32'd0);
        cycle(1, 1, 0, 0, '0, '0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, '0, '0);

        // Random traffic against the model
        rq0 = 1'b0;
        rq1 = 1'b0;
        ra0 = '0;
        ra1 = '0;
        for (int i = 0; i < 4000; i++) begin
            rq0 = rq0 ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
            rq1 = rq1 ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
            if (!rq0) ra0 = AW'($urandom);
            if (!rq1) ra1 = AW'($urandom);
            cycle(($urandom_range(0, 499) == 0), ($urandom_range(0, 4) != 0), rq0, rq1, ra0, ra1);
            if (bus.gnt0) ra0 = AW'($urandom);
            if (bus.gnt1) ra1 = AW'($urandom);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
